match_scorer: RTL and testbench

//  Parametrised N-player round/match scorekeeper for the Tron game. It tracks alive players per round
//  and awards the round to the last survivor. It holds between rounds, pulses reset_round, and declares
//  the match winner at WIN_SCORE. It sits between collision detection and the game-state FSM / score display.

---
 rtl/tron_score_pkg.sv | 24 ++
 rtl/match_scorer_frame_tick_gen.sv | 28 ++
 rtl/match_scorer.sv | 148 ++++++++++++++
 tb/tb_match_scorer.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/tron_score_pkg.sv
// Shared types and helpers for the Tron match scorekeeper.
package tron_score_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PLAY       = 2'd1,
    ROUND_END  = 2'd2,
    MATCH_OVER = 2'd3
  } score_state_t;

  localparam logic [2:0] GS_MENU = 3'd1;
  localparam logic [2:0] GS_PLAY = 3'd2;
  localparam int MAX_PLAYERS = 4;

  function automatic logic [2:0] popcount(input logic [MAX_PLAYERS-1:0] v);
    logic [2:0] c;
    c = 3'd0;
    for (int i = 0; i < MAX_PLAYERS; i++) begin
      c = c + {2'b00, v[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/match_scorer_frame_tick_gen.sv
// Synchronises the asynchronous frame strobe and emits a one-cycle tick on its rising edge.
module frame_tick_gen (
  input  logic clk,
  input  logic rst,
  input  logic frame_clk,
  output logic frame_tick
);

  logic sync1_r, sync2_r, prev_r, tick_r;

  // two-flop synchroniser, edge detector and registered tick
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      prev_r  <= 1'b0;
      tick_r  <= 1'b0;
    end else begin
      sync1_r <= frame_clk;
      sync2_r <= sync1_r;
      prev_r  <= sync2_r;
      tick_r  <= sync2_r & ~prev_r;
    end
  end

  assign frame_tick = tick_r;

endmodule

// File: rtl/match_scorer.sv
// Round/match scorekeeper for N-player Tron. Optional macro DRAW_POINTS_EN awards
// a point to every surviving player of a simultaneous-crash draw.
module match_scorer
  import tron_score_pkg::*;
#(
  parameter int NUM_PLAYERS = 2,
  parameter int SCORE_W     = 2,
  parameter int WIN_SCORE   = 3,
  parameter int HOLD_FRAMES = 60
) (
  input  logic                           Clk,
  input  logic                           Reset,
  input  logic                           frame_clk,
  input  logic [2:0]                     Game_State,
  input  logic [NUM_PLAYERS-1:0]         crash,
  output logic [NUM_PLAYERS*SCORE_W-1:0] score,
  output logic [NUM_PLAYERS-1:0]         alive,
  output logic [NUM_PLAYERS-1:0]         round_winner,
  output logic                           reset_round,
  output logic                           match_over,
  output logic [NUM_PLAYERS-1:0]         winner
);

  localparam int HOLD_W = $clog2(HOLD_FRAMES + 1);
  localparam logic [HOLD_W-1:0]  HOLD_LAST = HOLD_W'(HOLD_FRAMES - 1);
  localparam logic [SCORE_W-1:0] WIN_V     = SCORE_W'(WIN_SCORE);
  localparam logic [SCORE_W-1:0] ONE_V     = SCORE_W'(1);

  score_state_t                   state_r;
  logic [NUM_PLAYERS*SCORE_W-1:0] score_r, score_inc_s;
  logic [NUM_PLAYERS-1:0]         alive_r, round_winner_r, winner_r;
  logic                           reset_round_r, match_over_r;
  logic [HOLD_W-1:0]              hold_cnt_r;
  logic                           frame_tick_s;
  logic [NUM_PLAYERS-1:0]         alive_next_s, inc_mask_s, win_mask_s;
  logic [MAX_PLAYERS-1:0]         alive_pad_s;
  logic [2:0]                     alive_cnt_s;
  logic [SCORE_W-1:0]             cur_s;

  frame_tick_gen u_tick (
    .clk        (Clk),
    .rst        (Reset),
    .frame_clk  (frame_clk),
    .frame_tick (frame_tick_s)
  );

  // survivor count, points to award this round, and who has reached the winning score
  always_comb begin
    alive_next_s = alive_r & ~crash;
    alive_pad_s  = {MAX_PLAYERS{1'b0}};
    alive_pad_s[NUM_PLAYERS-1:0] = alive_next_s;
    alive_cnt_s  = popcount(alive_pad_s);
    if (alive_cnt_s == 3'd1) begin
      inc_mask_s = alive_next_s;
    end else if (alive_cnt_s == 3'd0) begin
`ifdef DRAW_POINTS_EN
      inc_mask_s = alive_r;
`else
      inc_mask_s = {NUM_PLAYERS{1'b0}};
`endif
    end else begin
      inc_mask_s = {NUM_PLAYERS{1'b0}};
    end
    score_inc_s = score_r;
    win_mask_s  = {NUM_PLAYERS{1'b0}};
    cur_s       = {SCORE_W{1'b0}};
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      cur_s = score_r[i*SCORE_W +: SCORE_W];
      win_mask_s[i] = (cur_s == WIN_V);
      if (inc_mask_s[i] && (cur_s < WIN_V)) begin
        score_inc_s[i*SCORE_W +: SCORE_W] = cur_s + ONE_V;
      end else begin
        score_inc_s[i*SCORE_W +: SCORE_W] = cur_s;
      end
    end
  end

  // round/match state machine; anything other than MENU or PLAY freezes it in place
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_r        <= IDLE;
      score_r        <= {(NUM_PLAYERS*SCORE_W){1'b0}};
      alive_r        <= {NUM_PLAYERS{1'b1}};
      round_winner_r <= {NUM_PLAYERS{1'b0}};
      winner_r       <= {NUM_PLAYERS{1'b0}};
      reset_round_r  <= 1'b0;
      match_over_r   <= 1'b0;
      hold_cnt_r     <= {HOLD_W{1'b0}};
    end else begin
      reset_round_r <= 1'b0;
      if (Game_State == GS_MENU) begin
        state_r        <= IDLE;
        score_r        <= {(NUM_PLAYERS*SCORE_W){1'b0}};
        alive_r        <= {NUM_PLAYERS{1'b1}};
        round_winner_r <= {NUM_PLAYERS{1'b0}};
        winner_r       <= {NUM_PLAYERS{1'b0}};
        match_over_r   <= 1'b0;
        hold_cnt_r     <= {HOLD_W{1'b0}};
      end else if (Game_State == GS_PLAY) begin
        case (state_r)
          IDLE: begin
            alive_r <= {NUM_PLAYERS{1'b1}};
            state_r <= PLAY;
          end
          PLAY: begin
            alive_r <= alive_next_s;
            if (alive_cnt_s <= 3'd1) begin
              score_r        <= score_inc_s;
              round_winner_r <= alive_next_s;
              hold_cnt_r     <= {HOLD_W{1'b0}};
              state_r        <= ROUND_END;
            end
          end
          ROUND_END: begin
            if (|win_mask_s) begin
              match_over_r <= 1'b1;
              winner_r     <= win_mask_s;
              state_r      <= MATCH_OVER;
            end else if (frame_tick_s) begin
              if (hold_cnt_r == HOLD_LAST) begin
                reset_round_r <= 1'b1;
                alive_r       <= {NUM_PLAYERS{1'b1}};
                hold_cnt_r    <= {HOLD_W{1'b0}};
                state_r       <= PLAY;
              end else begin
                hold_cnt_r <= hold_cnt_r + HOLD_W'(1);
              end
            end
          end
          MATCH_OVER: begin
            match_over_r <= 1'b1;
          end
          default: begin
            state_r <= IDLE;
          end
        endcase
      end
    end
  end

  assign score        = score_r;
  assign alive        = alive_r;
  assign round_winner = round_winner_r;
  assign reset_round  = reset_round_r;
  assign match_over   = match_over_r;
  assign winner       = winner_r;

endmodule

// File: tb/tb_match_scorer.sv
// Self-checking bench for match_scorer: directed scenarios followed by random rounds
// scored by a round-level reference model.
module tb_match_scorer;

  localparam int N  = 4;
  localparam int SW = 2;
  localparam int WS = 3;
  localparam int HF = 4;
  localparam logic [2:0] GS_MENU_T  = 3'd1;
  localparam logic [2:0] GS_PLAY_T  = 3'd2;
  localparam logic [2:0] GS_OTHER_T = 3'd4;
  localparam logic [N-1:0] ALL = 4'hF;

  logic          Clk = 1'b0;
  logic          Reset, frame_clk;
  logic [2:0]    Game_State;
  logic [N-1:0]  crash;
  logic [N*SW-1:0] score;
  logic [N-1:0]  alive, round_winner, winner;
  logic          reset_round, match_over;

  int n_checks = 0;
  int n_errors = 0;
  int rr_count = 0;
  int exp_score [N];
  logic [N-1:0] exp_alive, exp_rw;

  match_scorer #(.NUM_PLAYERS(N), .SCORE_W(SW), .WIN_SCORE(WS), .HOLD_FRAMES(HF)) dut (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .Game_State(Game_State), .crash(crash),
    .score(score), .alive(alive), .round_winner(round_winner), .reset_round(reset_round),
    .match_over(match_over), .winner(winner)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) begin
    if (reset_round === 1'b1) rr_count <= rr_count + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N*SW-1:0] packed_scores();
    logic [N*SW-1:0] p;
    p = '0;
    for (int i = 0; i < N; i++) p[i*SW +: SW] = exp_score[i][SW-1:0];
    return p;
  endfunction

  function automatic logic [N-1:0] at_win();
    logic [N-1:0] m;
    m = '0;
    for (int i = 0; i < N; i++) m[i] = (exp_score[i] == WS);
    return m;
  endfunction

  task automatic clear_model();
    for (int i = 0; i < N; i++) exp_score[i] = 0;
    exp_alive = ALL;
    exp_rw    = '0;
  endtask

  task automatic tick_frame();
    @(negedge Clk); frame_clk = 1'b1;
    repeat (3) @(negedge Clk);
    frame_clk = 1'b0;
    repeat (3) @(negedge Clk);
  endtask

  // Apply one crash pattern for a single clock and score the round if it ends.
  task automatic crash_step(input logic [N-1:0] m, output bit done);
    logic [N-1:0] nxt;
    @(negedge Clk); crash = m;
    @(negedge Clk); crash = '0;
    nxt  = exp_alive & ~m;
    done = ($countones(nxt) <= 1);
    if (done) begin
      if ($countones(nxt) == 1) begin
        for (int i = 0; i < N; i++) if (nxt[i] && exp_score[i] < WS) exp_score[i]++;
      end else begin
`ifdef DRAW_POINTS_EN
        for (int i = 0; i < N; i++) if (exp_alive[i] && exp_score[i] < WS) exp_score[i]++;
`endif
      end
      exp_rw = nxt;
    end
    exp_alive = nxt;
    check("alive", alive, exp_alive);
    if (done) begin
      check("score", score, packed_scores());
      check("round_winner", round_winner, exp_rw);
    end
  endtask

  task automatic new_match();
    @(negedge Clk); Game_State = GS_MENU_T;
    @(negedge Clk); Game_State = GS_PLAY_T;
    clear_model();
    check("menu_score", score, '0);
    check("menu_winner", winner, '0);
    check("menu_match_over", match_over, 1'b0);
    check("menu_round_winner", round_winner, '0);
    @(negedge Clk);
    check("menu_alive", alive, ALL);
  endtask

  task automatic finish_round();
    int rr0;
    if (at_win() != '0) begin
      @(negedge Clk);
      check("match_over", match_over, 1'b1);
      check("winner", winner, at_win());
      rr0 = rr_count;
      repeat (HF) tick_frame();
      check("no_respawn_after_match", rr_count - rr0, 0);
      check("match_over_held", match_over, 1'b1);
      new_match();
    end else begin
      rr0 = rr_count;
      repeat (HF - 1) tick_frame();
      check("early_respawn", rr_count - rr0, 0);
      tick_frame();
      check("respawn_pulse", rr_count - rr0, 1);
      exp_alive = ALL;
      check("respawn_alive", alive, exp_alive);
    end
  endtask

  initial begin
    bit done;
    int rr0;
    int steps;
    Reset = 1'b1; Game_State = 3'd0; crash = '0; frame_clk = 1'b0;
    clear_model();
    repeat (2) @(negedge Clk);
    check("rst_score", score, '0);
    check("rst_alive", alive, ALL);
    check("rst_round_winner", round_winner, '0);
    check("rst_reset_round", reset_round, 1'b0);
    check("rst_match_over", match_over, 1'b0);
    check("rst_winner", winner, '0);
    Reset = 1'b0;
    Game_State = GS_PLAY_T;
    @(negedge Clk);

    // single survivor, then a crash during the hold is ignored
    crash_step(4'b1110, done);
    @(negedge Clk); crash = 4'b0001;
    @(negedge Clk); crash = '0;
    check("hold_crash_alive", alive, exp_alive);
    check("hold_crash_score", score, packed_scores());
    finish_round();

    // players drop out one at a time; a dead player's crash does nothing
    crash_step(4'b0100, done);
    crash_step(4'b1000, done);
    crash_step(4'b0100, done);
    crash_step(4'b0001, done);
    finish_round();

    // simultaneous crash
    crash_step(4'b1111, done);
    finish_round();

    // freeze mid-play: crash ignored, no frames counted
    @(negedge Clk); Game_State = GS_OTHER_T; crash = 4'b0001;
    @(negedge Clk); crash = '0;
    repeat (10) tick_frame();
    check("freeze_play_alive", alive, exp_alive);
    Game_State = GS_PLAY_T;
    crash_step(4'b1011, done);
    rr0 = rr_count;
    repeat (2) tick_frame();
    Game_State = GS_OTHER_T;
    repeat (10) tick_frame();
    check("freeze_hold_no_pulse", rr_count - rr0, 0);
    check("freeze_hold_alive", alive, exp_alive);
    Game_State = GS_PLAY_T;
    repeat (HF - 3) tick_frame();
    check("resume_hold_early", rr_count - rr0, 0);
    tick_frame();
    check("resume_hold_pulse", rr_count - rr0, 1);
    exp_alive = ALL;

    // player 1 takes three straight rounds
    new_match();
    for (int r = 0; r < 3; r++) begin
      crash_step(4'b1101, done);
      finish_round();
    end

    // asynchronous reset in the middle of the hold
    crash_step(4'b0111, done);
    tick_frame();
    @(negedge Clk);
    #2 Reset = 1'b1;
    #1;
    clear_model();
    check("async_score", score, '0);
    check("async_alive", alive, ALL);
    check("async_round_winner", round_winner, '0);
    check("async_match_over", match_over, 1'b0);
    check("async_reset_round", reset_round, 1'b0);
    rr0 = rr_count;
    repeat (3) @(negedge Clk);
    Reset = 1'b0;
    repeat (2) @(negedge Clk);
    check("async_no_pulse", rr_count - rr0, 0);

    // random rounds
    for (int r = 0; r < 30; r++) begin
      done = 1'b0;
      steps = 0;
      while (!done && steps < 40) begin
        crash_step(N'($urandom_range(1, 15)), done);
        steps++;
      end
      if (!done) crash_step(ALL, done);
      finish_round();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
